feature_window: RTL and testbench
=================================

FEATURE_WINDOW -- requirements
Module: feature_window

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the sample width in bits.
REQ-002 Parameter WINDOW, default 8, SHALL set samples per feature window; legal values are powers of two, 2..256.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  SHALL carry the upstream assembled sample, valid while data_ready=1.
REQ-006 data_ready  input  1  SHALL indicate that upstream holds a valid sample.
REQ-007 data_processed  output  1  SHALL be a one-cycle pulse acknowledging capture of data_in.
REQ-008 feature_valid  output  1  SHALL indicate that feat_min, feat_max, feat_mean and feat_range are valid.
REQ-009 feature_ack  input  1  SHALL be the downstream consumer's acceptance of the feature set.
REQ-010 feat_min, feat_max, feat_mean  output  DATA_WIDTH each  SHALL give the window minimum, maximum and truncated mean.
REQ-011 feat_range  output  DATA_WIDTH  SHALL give feat_max minus feat_min (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, CAPTURE, RELEASE and EMIT.
REQ-013 IDLE, data_ready=1: at the next edge, register data_in into the accumulators and go to CAPTURE.
REQ-014 CAPTURE: data_processed=1 for exactly that cycle, then go to RELEASE unconditionally.
REQ-015 RELEASE: wait until data_ready=0. Then go to EMIT if the sample count equals WINDOW, otherwise go to IDLE.
REQ-016 A single data_ready assertion SHALL never be captured twice, even if upstream holds data_ready high after the pulse.
REQ-017 Accumulators SHALL consist of a running min, a running max, a sum of width DATA_WIDTH+log2(WINDOW) (never overflows), and a sample count.
REQ-018 The first sample of a window SHALL load min and max directly.
REQ-019 Comparisons SHALL be unsigned; on equal values, min and max are unchanged.
REQ-020 feat_mean SHALL be sum >> log2(WINDOW), truncating.
REQ-021 EMIT: feature_valid=1 and all feat_* held stable until feature_ack=1 is sampled.
REQ-022 On feature_ack in EMIT, at that edge: clear feature_valid, clear all accumulators, go to IDLE.
REQ-023 feature_ack outside EMIT SHALL be ignored.
REQ-024 No sample SHALL be accepted while in EMIT (backpressure); data_processed stays 0.
REQ-025 Latency: data_ready seen in IDLE at cycle T gives data_processed=1 in cycle T+1.
REQ-026 Latency: the WINDOW-th sample's data_processed at cycle T gives feature_valid=1 no earlier than T+2, once data_ready has fallen.
REQ-027 feat_* outputs SHALL update only on entry to EMIT.

Reset
REQ-028 On reset=1 at an edge, the block SHALL clear data_processed, feature_valid and all feat_* to 0.
REQ-029 On reset, accumulators and sample count SHALL be cleared and the FSM SHALL go to IDLE.
REQ-030 Reset SHALL take priority over every other event, including mid-window and during EMIT; a partial window is discarded.

Configuration
REQ-031 Macro FEATURE_WINDOW_RANGE_EN defined: feat_range SHALL be computed as max-min and registered on entry to EMIT.
REQ-032 Macro FEATURE_WINDOW_RANGE_EN undefined: feat_range SHALL be tied to 0 and no subtractor shall be synthesized.

Verification
REQ-033 WINDOW=4, range enabled; samples 10,20,30,40 -> feat_min=10, feat_max=40, feat_mean=25, feat_range=30, feature_valid=1.
REQ-034 WINDOW=4; four samples of 255 -> feat_mean=255, feat_min=feat_max=255, feat_range=0 (no sum overflow).
REQ-035 data_ready held high 10 cycles with one sample -> exactly one data_processed pulse, and count advances by 1.
REQ-036 Window complete, feature_ack low 20 cycles while data_ready=1 -> feature_valid and outputs stable, data_processed=0 throughout; ack -> IDLE, then next sample captured.
REQ-037 reset=1 after 2 of 4 samples -> all outputs 0; then samples 5,6,7,8 -> feat_min=5, feat_max=8, feat_mean=6.
REQ-038 Macro undefined, samples 10,20,30,40 -> feat_range=0 and other features unchanged from REQ-033.

Source files
------------

// File: rtl/feature_window_if.sv
// feature_window_if: sample handshake and feature-set bundle between upstream, feature_window and its consumer
interface feature_window_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_ready;
  logic                  data_processed;
  logic                  feature_valid;
  logic                  feature_ack;
  logic [DATA_WIDTH-1:0] feat_min;
  logic [DATA_WIDTH-1:0] feat_max;
  logic [DATA_WIDTH-1:0] feat_mean;
  logic [DATA_WIDTH-1:0] feat_range;
  modport master (
    output data_in, data_ready, feature_ack,
    input  data_processed, feature_valid, feat_min, feat_max, feat_mean, feat_range
  );
  modport slave (
    input  data_in, data_ready, feature_ack,
    output data_processed, feature_valid, feat_min, feat_max, feat_mean, feat_range
  );
endinterface

// File: rtl/feature_window.sv
// feature_window: windowed min/max/mean (and max-min when FEATURE_WINDOW_RANGE_EN is defined) over WINDOW samples
module feature_window #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  feature_window_if.slave bus
);
  localparam int LW = $clog2(WINDOW);
  typedef enum logic [1:0] {IDLE, CAPTURE, RELEASE, EMIT} state_e;
  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  min_q, min_d, max_q, max_d;
  logic [DATA_WIDTH+LW-1:0] sum_q, sum_d;
  logic [LW:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  fmin_q, fmax_q, fmean_q;
  logic                   take, full, emit_go, done, first;
  assign take    = state_q == IDLE && bus.data_ready;
  assign full    = cnt_q == (LW+1)'(WINDOW);
  assign emit_go = state_q == RELEASE && !bus.data_ready && full;
  assign done    = state_q == EMIT && bus.feature_ack;
  assign first   = cnt_q == '0;
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = take ? CAPTURE :
              state_q == CAPTURE ? RELEASE :
              (state_q == RELEASE && !bus.data_ready) ? (full ? EMIT : IDLE) :
              done ? IDLE : state_q;
  end
  always_comb begin
    bus.data_processed = state_q == CAPTURE;
    bus.feature_valid  = state_q == EMIT;
  end
  always_comb begin
    min_d = done ? '0 : (take && (first || bus.data_in < min_q)) ? bus.data_in : min_q;
    max_d = done ? '0 : (take && (first || bus.data_in > max_q)) ? bus.data_in : max_q;
    sum_d = done ? '0 : take ? sum_q + (DATA_WIDTH+LW)'(bus.data_in) : sum_q;
    cnt_d = done ? '0 : take ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fmin_q  <= '0;
      fmax_q  <= '0;
      fmean_q <= '0;
    end else if (emit_go) begin
      fmin_q  <= min_q;
      fmax_q  <= max_q;
      fmean_q <= DATA_WIDTH'(sum_q >> LW);
    end
  end
  assign bus.feat_min  = fmin_q;
  assign bus.feat_max  = fmax_q;
  assign bus.feat_mean = fmean_q;
`ifdef FEATURE_WINDOW_RANGE_EN
  logic [DATA_WIDTH-1:0] frange_q;
  always_ff @(posedge clk) begin
    if (reset) frange_q <= '0;
    else if (emit_go) frange_q <= max_q - min_q;
  end
  assign bus.feat_range = frange_q;
`else
  assign bus.feat_range = '0;
`endif
endmodule

// File: tb/tb_feature_window.sv
// tb_feature_window: directed and randomized windows against a queue-based reference model
module tb_feature_window;
  localparam int W = 4;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int win[$];
  int p;
  feature_window_if #(.DATA_WIDTH(8)) bus();
  feature_window #(.DATA_WIDTH(8), .WINDOW(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_feat(input string tag);
    int mn = 255, mx = 0, sm = 0;
    foreach (win[i]) begin
      mn = win[i] < mn ? win[i] : mn;
      mx = win[i] > mx ? win[i] : mx;
      sm += win[i];
    end
    chk({tag, "_valid"}, 32'(bus.feature_valid), 1);
    chk({tag, "_min"}, 32'(bus.feat_min), mn);
    chk({tag, "_max"}, 32'(bus.feat_max), mx);
    chk({tag, "_mean"}, 32'(bus.feat_mean), sm / W);
`ifdef FEATURE_WINDOW_RANGE_EN
    chk({tag, "_range"}, 32'(bus.feat_range), mx - mn);
`else
    chk({tag, "_range"}, 32'(bus.feat_range), 0);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dp"}, 32'(bus.data_processed), 0);
    chk({tag, "_valid"}, 32'(bus.feature_valid), 0);
    chk({tag, "_min"}, 32'(bus.feat_min), 0);
    chk({tag, "_max"}, 32'(bus.feat_max), 0);
    chk({tag, "_mean"}, 32'(bus.feat_mean), 0);
    chk({tag, "_range"}, 32'(bus.feat_range), 0);
  endtask

  task automatic feed(input string tag, input logic [7:0] v, input int hold);
    int pulses = 0;
    bus.data_in = v;
    bus.data_ready = 1;
    repeat (hold) begin
      @(negedge clk);
      if (bus.data_processed) pulses++;
    end
    bus.data_ready = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.data_processed) pulses++;
    end
    win.push_back(int'(v));
    chk({tag, "_pulses"}, pulses, 1);
    if (win.size() == W) check_feat(tag);
    else chk({tag, "_novalid"}, 32'(bus.feature_valid), 0);
  endtask

  task automatic ack(input string tag);
    bus.feature_ack = 1;
    @(negedge clk);
    bus.feature_ack = 0;
    win.delete();
    chk({tag, "_ackclr"}, 32'(bus.feature_valid), 0);
  endtask

  initial begin
    reset = 1;
    bus.data_in = 0;
    bus.data_ready = 0;
    bus.feature_ack = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    check_zero("rst");
    feed("basic", 10, 1); feed("basic", 20, 2); feed("basic", 30, 1); feed("basic", 40, 3);
    ack("basic");
    repeat (4) feed("sat", 255, 1);
    ack("sat");
    feed("hold", 7, 10); feed("hold", 3, 1); feed("hold", 9, 1); feed("hold", 7, 1);
    ack("hold");
    feed("ign", 50, 1);
    bus.feature_ack = 1;
    @(negedge clk);
    bus.feature_ack = 0;
    chk("ign_idle", 32'(bus.feature_valid), 0);
    feed("ign", 60, 1); feed("ign", 50, 1); feed("ign", 45, 2);
    bus.data_in = 99;
    bus.data_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_dp", 32'(bus.data_processed), 0);
      check_feat("bp");
    end
    ack("bp");
    @(negedge clk);
    chk("bp_next_dp", 32'(bus.data_processed), 1);
    win.push_back(99);
    bus.data_ready = 0;
    repeat (2) @(negedge clk);
    feed("bp2", 1, 1); feed("bp2", 200, 1); feed("bp2", 17, 1);
    ack("bp2");
    feed("part", 1, 1); feed("part", 2, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    win.delete();
    check_zero("midrst");
    feed("post", 5, 1); feed("post", 6, 1); feed("post", 7, 1); feed("post", 8, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    win.delete();
    check_zero("emitrst");
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < W; j++) feed("rand", 8'($urandom), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_feat("rand_wait");
      ack("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
